wb_writeback_queue: RTL and testbench
=====================================

// Module: wb_writeback_queue
// PURPOSE
//  Writeback-side initiator for the register-file write port. Accepts completed results from the
//  mem stage (valid/ready), aligns and extends load data, buffers them in a small in-order queue
//  and drives exactly one write per cycle into the register file (write_enable/addr/data).
//  Exposes a query port so id-stage hazard logic can forward from writes not yet retired.
// PARAMETERS
//  XLEN        32  data width of register writes
//  REG_ADDR_W  5   register address width
//  DEPTH       2   queue entries, power of two, >=2
// PORTS
//  clk           in   1           clock
//  rst           in   1           reset, synchronous, active-high
//  in_valid      in   1           mem stage has a result
//  in_ready      out  1           queue can accept this cycle
//  in_rd         in   REG_ADDR_W  destination register
//  in_data       in   XLEN        ALU result or raw load word
//  in_is_load    in   1           apply load alignment to in_data
//  in_funct3     in   3           load type (LB/LH/LW/LBU/LHU)
//  in_byte_off   in   2           address[1:0] of the load
//  stall         in   1           stall controller: hold, issue no write
//  write_enable  out  1           to register file
//  write_addr    out  REG_ADDR_W  to register file
//  write_data    out  XLEN        to register file
//  q_addr        in   REG_ADDR_W  hazard query address from id
//  q_hit         out  1           q_addr has a pending/in-flight write
//  q_data        out  XLEN        youngest pending value for q_addr
// BEHAVIOUR
//  - Reset: queue emptied; write_enable=0, write_addr=0, write_data=0; reset mid-operation
//    discards all queued entries, no write issued in the cycle after reset.
//  - in_ready = (count < DEPTH); independent of stall and of a same-cycle pop.
//  - Accept on posedge when in_valid && in_ready. Entries with in_rd==0 are accepted and
//    discarded (never queued, never written).
//  - Alignment at accept when in_is_load: lane = in_data >> (8*in_byte_off); funct3 000 LB
//    sign-ext byte, 001 LH sign-ext half (lane by in_byte_off[1] only), 010 LW whole word,
//    100 LBU / 101 LHU zero-ext; any other funct3 treated as LW. Non-loads stored unchanged.
//  - Issue: on posedge, if !stall and count>0, pop head into write_* registers with
//    write_enable=1; otherwise write_enable=0 (addr/data hold last value). Each entry
//    produces exactly one single-cycle write_enable pulse, in acceptance order.
//  - Latency: accept at edge N, earliest write_enable high after edge N+1. Push and pop in the
//    same edge are both performed; count updates by +1, -1 or 0 accordingly.
//  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits, never exceeds DEPTH.
//  - Stall mid-stream: queue holds, accepts continue until full, issue resumes with the
//    same head entry after stall drops; no entry skipped or duplicated.
//  - Query (combinational): q_hit=0 if q_addr==0; else 1 if any valid queue entry or the
//    current write_enable=1 output matches. q_data = youngest match (newest queue entry,
//    then older entries, then write_data); 0 when no hit.
// CONFIGURATION
//  WB_COUNT_EN defined: extra output wb_count [31:0], reset 0, +1 on every cycle
//    write_enable=1, wraps at 2^32. Undefined: port and counter absent; all else identical.
// TESTING
//  - ALU result rd=5 data=0x1234 single push, stall=0 -> one write_enable pulse, addr 5,
//    data 0x1234, two edges after accept; in_ready stays 1.
//  - Loads word 0x80FF7F01: LB off=1 -> 0x0000007F; LB off=2 -> 0xFFFFFFFF; LHU off=2 ->
//    0x000080FF; LH off=2 -> 0xFFFF80FF; funct3=011 -> 0x80FF7F01.
//  - stall=1, push rd=1,2,3 -> in_ready drops after 2 accepts, third held; release stall ->
//    writes rd1, rd2, rd3 in order on consecutive cycles, no gaps or duplicates.
//  - Push rd=0 data=0xDEAD -> no write_enable pulse; q_addr=0 -> q_hit=0.
//  - Queue rd=7 =0xA then rd=7 =0xB under stall, q_addr=7 -> q_hit=1, q_data=0xB; after
//    first retires q_data still 0xB; after both retire and pulse ends q_hit=0.
//  - rst asserted with 2 entries queued -> next cycle write_enable=0, in_ready=1, q_hit=0;
//    with WB_COUNT_EN, wb_count=0 after reset and equals pulses seen otherwise.

Source files
------------

// File: rtl/wb_writeback_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_writeback_queue: in-order writeback queue with load alignment and hazard query; WB_COUNT_EN adds wb_count.
// Revision: 1.0
// ---------------------------------------------------------------------------
module wb_writeback_queue #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]       in_data,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [1:0]            in_byte_off,
  input  logic                  stall,
  output logic                  write_enable,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [XLEN-1:0]       write_data,
  input  logic [REG_ADDR_W-1:0] q_addr,
  output logic                  q_hit,
  output logic [XLEN-1:0]       q_data
`ifdef WB_COUNT_EN
  ,
  output logic [31:0]           wb_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
  logic [XLEN-1:0]       data_mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic                  push;
  logic                  pop;
  logic [7:0]            lane;
  logic [15:0]           half;
  logic [XLEN-1:0]       aligned;

  assign in_ready = (count < CNT_W'(DEPTH));
  // Writes to x0 are consumed here so they never occupy a slot.
  assign push     = in_valid & in_ready & (in_rd != '0);
  assign pop      = ~stall & (count != '0);

  always_comb begin
    lane    = 8'(in_data >> {in_byte_off, 3'b000});
    half    = 16'(in_data >> {in_byte_off[1], 4'b0000});
    aligned = in_data;
    if (in_is_load) begin
      case (in_funct3)
        3'b000:  aligned = {{(XLEN-8){lane[7]}}, lane};
        3'b001:  aligned = {{(XLEN-16){half[15]}}, half};
        3'b100:  aligned = {{(XLEN-8){1'b0}}, lane};
        3'b101:  aligned = {{(XLEN-16){1'b0}}, half};
        default: aligned = in_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail]   <= in_rd;
      data_mem[tail] <= aligned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        write_enable <= 1'b1;
        write_addr   <= rd_mem[head];
        write_data   <= data_mem[head];
        head         <= head + PTR_W'(1);
      end else begin
        write_enable <= 1'b0;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Scan oldest to youngest so the last match left standing is the newest value.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    if (q_addr != '0) begin
      if (write_enable && (write_addr == q_addr)) begin
        q_hit  = 1'b1;
        q_data = write_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < count) && (rd_mem[head + PTR_W'(i)] == q_addr)) begin
          q_hit  = 1'b1;
          q_data = data_mem[head + PTR_W'(i)];
        end
      end
    end
  end

`ifdef WB_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_count <= '0;
    end else if (write_enable) begin
      wb_count <= wb_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_writeback_queue.sv
`default_nettype none
// tb_wb_writeback_queue: queue-based reference model checked every cycle, plus directed literal checks.
module tb_wb_writeback_queue;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_data = '0;
  logic        in_is_load = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [1:0]  in_byte_off = '0;
  logic        stall = 1'b0;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  q_addr = '0;
  logic        q_hit;
  logic [31:0] q_data;
`ifdef WB_COUNT_EN
  logic [31:0] wb_count;
`endif

  wb_writeback_queue #(.XLEN(32), .REG_ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .in_is_load(in_is_load), .in_funct3(in_funct3), .in_byte_off(in_byte_off),
    .stall(stall),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data)
`ifdef WB_COUNT_EN
    , .wb_count(wb_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of pending results plus the registered write port.
  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [31:0] m_pulses;

  function automatic logic [31:0] m_align(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit   rdy;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_we = 1'b0; m_wa = '0; m_wd = '0; m_pulses = '0;
      run = 1'b1;
    end else begin
      rdy = (mq.size() < DEPTH);
      if (m_we) m_pulses = m_pulses + 32'd1;
      if (!stall && mq.size() > 0) begin
        e = mq.pop_front();
        m_we = 1'b1; m_wa = e.rd; m_wd = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (in_valid && rdy && in_rd != 5'd0) begin
        e.rd = in_rd;
        e.d  = in_is_load ? m_align(in_data, in_funct3, in_byte_off) : in_data;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin : compare
    logic        eh;
    logic [31:0] ed;
    bit          found;
    if (run) begin
      eh = 1'b0; ed = '0; found = 1'b0;
      if (q_addr != 5'd0) begin
        for (int i = mq.size() - 1; i >= 0; i--) begin
          if (!found && mq[i].rd == q_addr) begin
            found = 1'b1; eh = 1'b1; ed = mq[i].d;
          end
        end
        if (!found && m_we && m_wa == q_addr) begin
          eh = 1'b1; ed = m_wd;
        end
      end
      chk("m_in_ready", in_ready, (mq.size() < DEPTH));
      chk("m_write_enable", write_enable, m_we);
      chk("m_write_addr", write_addr, m_wa);
      chk("m_write_data", write_data, m_wd);
      chk("m_q_hit", q_hit, eh);
      chk("m_q_data", q_data, ed);
`ifdef WB_COUNT_EN
      chk("m_wb_count", wb_count, m_pulses);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [4:0] rd, input logic [31:0] d);
    in_valid = 1'b1; in_rd = rd; in_data = d; in_is_load = 1'b0;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_write(input string nm, input logic [4:0] a, input logic [31:0] d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!write_enable && n < 10);
    chk({nm, "_we"}, write_enable, 1);
    chk({nm, "_addr"}, write_addr, a);
    chk({nm, "_data"}, write_data, d);
  endtask

  task automatic load_case(input string nm, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] exp);
    in_valid = 1'b1; in_rd = 5'd10; in_data = 32'h80FF7F01;
    in_is_load = 1'b1; in_funct3 = f3; in_byte_off = off;
    tick();
    in_valid = 1'b0; in_is_load = 1'b0;
    wait_write(nm, 5'd10, exp);
    tick();
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_we", write_enable, 0);
    chk("rst_addr", write_addr, 0);
    chk("rst_data", write_data, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_qhit", q_hit, 0);

    // Single ALU result: pulse two edges after accept.
    tick();
    in_valid = 1'b1; in_rd = 5'd5; in_data = 32'h1234;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("alu_we_early", write_enable, 0);
    chk("alu_ready", in_ready, 1);
    @(negedge clk);
    chk("alu_we", write_enable, 1);
    chk("alu_addr", write_addr, 5);
    chk("alu_data", write_data, 32'h1234);
    @(negedge clk);
    chk("alu_we_end", write_enable, 0);

    tick();
    load_case("lb_off1", 3'b000, 2'd1, 32'h0000007F);
    load_case("lb_off2", 3'b000, 2'd2, 32'hFFFFFFFF);
    load_case("lhu_off2", 3'b101, 2'd2, 32'h000080FF);
    load_case("lh_off2", 3'b001, 2'd2, 32'hFFFF80FF);
    load_case("f3_011", 3'b011, 2'd0, 32'h80FF7F01);

    // Backpressure under stall, then ordered drain.
    stall = 1'b1; in_valid = 1'b1; in_rd = 5'd1; in_data = 32'h11;
    tick();
    in_rd = 5'd2; in_data = 32'h22;
    tick();
    in_rd = 5'd3; in_data = 32'h33;
    @(negedge clk);
    chk("full_ready", in_ready, 0);
    chk("full_we", write_enable, 0);
    tick();
    @(negedge clk);
    chk("full_ready2", in_ready, 0);
    tick();
    stall = 1'b0;
    tick();
    @(negedge clk);
    chk("drain1_we", write_enable, 1);
    chk("drain1_addr", write_addr, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain2_we", write_enable, 1);
    chk("drain2_addr", write_addr, 2);
    tick();
    @(negedge clk);
    chk("drain3_we", write_enable, 1);
    chk("drain3_addr", write_addr, 3);
    chk("drain3_data", write_data, 32'h33);
    tick();
    @(negedge clk);
    chk("drain_end", write_enable, 0);

    // x0 destination is dropped.
    q_addr = 5'd0;
    push_one(5'd0, 32'hDEAD);
    repeat (3) begin
      @(negedge clk);
      chk("x0_we", write_enable, 0);
      chk("x0_qhit", q_hit, 0);
    end

    // Forwarding picks the youngest pending value.
    tick();
    stall = 1'b1;
    push_one(5'd7, 32'hA);
    push_one(5'd7, 32'hB);
    q_addr = 5'd7;
    @(negedge clk);
    chk("fwd_hit", q_hit, 1);
    chk("fwd_data", q_data, 32'hB);
    tick();
    stall = 1'b0;
    tick();
    @(negedge clk);
    chk("fwd1_wdata", write_data, 32'hA);
    chk("fwd1_data", q_data, 32'hB);
    tick();
    @(negedge clk);
    chk("fwd2_wdata", write_data, 32'hB);
    chk("fwd2_hit", q_hit, 1);
    chk("fwd2_data", q_data, 32'hB);
    tick();
    @(negedge clk);
    chk("fwd3_hit", q_hit, 0);
    chk("fwd3_data", q_data, 0);

    // Reset with two entries queued.
    tick();
    stall = 1'b1;
    push_one(5'd8, 32'h88);
    push_one(5'd9, 32'h99);
    q_addr = 5'd8;
    @(negedge clk);
    chk("prerst_hit", q_hit, 1);
    tick();
    rst = 1'b1; stall = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_we", write_enable, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_qhit", q_hit, 0);
`ifdef WB_COUNT_EN
    chk("midrst_count", wb_count, 0);
`endif
    tick();
    @(negedge clk);
    chk("postrst_we", write_enable, 0);

    // Mixed traffic exercising pointer wrap, stalls and x0 drops.
    for (int i = 0; i < 24; i++) begin
      in_valid    = (i % 4 != 3);
      in_rd       = 5'(i % 6);
      in_data     = 32'h80FF7F01 + 32'(i * 32'h01010101);
      in_is_load  = (i % 3 == 0);
      in_funct3   = 3'(i % 8);
      in_byte_off = 2'(i % 4);
      stall       = (i % 5 == 2) || (i % 7 == 4);
      q_addr      = 5'((i + 1) % 6);
      tick();
    end
    in_valid = 1'b0; stall = 1'b0;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
